// File: rtl/conv_window_ctrl_if.sv
// Handshake and status bundle between a pixel source/window datapath and conv_window_ctrl.
// Latency: none, this is wiring only.
// Backpressure: pix_ready_o is the only flow-control signal toward the pixel source.
interface conv_window_ctrl_if #(
  parameter int CW = 16
);
  logic          start_i;
  logic          abort_i;
  logic          pix_valid_i;
  logic          pix_ready_o;
  logic          win_clr_o;
  logic          win_en_o;
  logic          line_en_o;
  logic [CW-1:0] col_o;
  logic [CW-1:0] row_o;
  logic          win_valid_o;
  logic [CW-1:0] win_cnt_o;
  logic          busy_o;
  logic          frame_done_o;

  // Controller side
  modport slave (
    input  start_i, abort_i, pix_valid_i,
    output pix_ready_o, win_clr_o, win_en_o, line_en_o, col_o, row_o,
           win_valid_o, win_cnt_o, busy_o, frame_done_o
  );

  // Source / supervisor side
  modport master (
    output start_i, abort_i, pix_valid_i,
    input  pix_ready_o, win_clr_o, win_en_o, line_en_o, col_o, row_o,
           win_valid_o, win_cnt_o, busy_o, frame_done_o
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// Sequences one IMG_W x IMG_H frame through a KxK window datapath: clear, scan, done.
// Latency: enables and win_valid_o are combinational with the accept; counters update on the edge.
// Backpressure: pixels are taken only in RUN; col/row hold on any cycle without an accept.
module conv_window_ctrl #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int K     = 3,
  parameter int CW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  conv_window_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CW-1:0] L_COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] L_ROW_LAST = CW'(IMG_H - 1);
  localparam logic [CW-1:0] L_WIN_MIN  = CW'(K - 1);
  localparam logic [CW-1:0] L_ONE      = CW'(1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_col;
  logic [CW-1:0] r_row;
  logic [CW-1:0] r_cnt;

  logic w_ready;
  logic w_accept;
  logic w_col_last;
  logic w_row_last;
  logic w_frame_last;
  logic w_win;

  // Outputs are gated by rst so nothing is asserted while reset is held, even mid-frame.
  assign w_ready      = (r_state == RUN) && !rst;
  assign w_accept     = bus.pix_valid_i && w_ready;
  assign w_col_last   = (r_col == L_COL_LAST);
  assign w_row_last   = (r_row == L_ROW_LAST);
  assign w_frame_last = w_col_last && w_row_last;
  // Uses the pre-increment position: the pixel being accepted completes the window.
  assign w_win        = w_accept && (r_row >= L_WIN_MIN) && (r_col >= L_WIN_MIN);

  assign bus.pix_ready_o  = w_ready;
  assign bus.win_en_o     = w_accept;
  assign bus.line_en_o    = w_accept;
  assign bus.win_valid_o  = w_win;
  assign bus.win_clr_o    = (r_state == CLR) && !rst;
  assign bus.busy_o       = (r_state != IDLE) && !rst;
  // An abort in DONE swallows the pulse so aborted frames never report completion.
  assign bus.frame_done_o = (r_state == DONE) && !bus.abort_i && !rst;
  assign bus.col_o        = r_col;
  assign bus.row_o        = r_row;
  assign bus.win_cnt_o    = r_cnt;

  // State register; reset dominates abort and start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort wins over every transition except start out of IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start_i) begin
          w_state_nxt = CLR;
        end
      end
      CLR: begin
        w_state_nxt = bus.abort_i ? IDLE : RUN;
      end
      RUN: begin
        if (bus.abort_i) begin
          w_state_nxt = IDLE;
        end else if (w_accept && w_frame_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Raster position and window count; an accept in an abort cycle still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_cnt <= '0;
    end else if (r_state == CLR) begin
      r_col <= '0;
      r_row <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : (r_row + L_ONE);
      end else begin
        r_col <= r_col + L_ONE;
      end
      if (w_win) begin
        r_cnt <= r_cnt + L_ONE;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Randomized and directed bench for conv_window_ctrl with a raster-index reference model.
// Latency: expected values are queued at drive time and compared at the following negedge.
// Backpressure: pix_valid_i patterns (held, gapped, random) exercise stall behaviour.
module tb_conv_window_ctrl;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int KK = 3;
  localparam int CW = 16;
  localparam int NWIN = (W - KK + 1) * (H - KK + 1);

  localparam int P_IDLE = 0;
  localparam int P_CLR  = 1;
  localparam int P_RUN  = 2;
  localparam int P_DONE = 3;

  typedef struct packed {
    logic          rdy;
    logic          clr;
    logic          wen;
    logic          len;
    logic          winv;
    logic          done;
    logic          busy;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [CW-1:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  logic rst_s;

  conv_window_ctrl_if #(.CW(CW)) mif ();
  conv_window_ctrl_if #(.CW(CW)) sif ();

  conv_window_ctrl #(.IMG_W(W), .IMG_H(H), .K(KK), .CW(CW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  conv_window_ctrl #(.IMG_W(3), .IMG_H(3), .K(3), .CW(CW)) u_small (
    .clk (clk),
    .rst (rst_s),
    .bus (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  exp_t          cyc_q[$];
  logic [2*CW:0] acc_q[$];

  // Reference model: frame progress expressed as a count of accepted pixels.
  int m_ph  = P_IDLE;
  int m_acc = 0;
  int m_win = 0;

  // Monitor statistics
  int cyc_no     = 0;
  int n_acc_seen = 0;
  int n_winp     = 0;
  int n_donep    = 0;
  int n_clrp     = 0;
  int first_win  = 0;
  int acc64_cyc  = 0;
  int done_cyc   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    n_acc_seen = 0;
    n_winp     = 0;
    n_donep    = 0;
    n_clrp     = 0;
    first_win  = 0;
    acc64_cyc  = 0;
    done_cyc   = 0;
  endtask

  // One cycle of stimulus plus the model's prediction for that cycle.
  task automatic cyc(input logic v, input logic s, input logic a, input logic r);
    exp_t e;
    int   c;
    int   rw;
    logic acc;
    logic last;
    @(posedge clk);
    #1;
    mif.pix_valid_i = v;
    mif.start_i     = s;
    mif.abort_i     = a;
    rst             = r;

    c  = m_acc % W;
    rw = m_acc / W;
    e.rdy  = (m_ph == P_RUN) && !r;
    e.clr  = (m_ph == P_CLR) && !r;
    e.busy = (m_ph != P_IDLE) && !r;
    e.done = (m_ph == P_DONE) && !a && !r;
    acc    = v && e.rdy;
    e.wen  = acc;
    e.len  = acc;
    e.winv = acc && (rw >= KK - 1) && (c >= KK - 1);
    e.col  = CW'(c);
    e.row  = CW'(rw);
    e.cnt  = CW'(m_win);
    cyc_q.push_back(e);
    if (acc) acc_q.push_back({CW'(c), CW'(rw), e.winv});

    last = 1'b0;
    if (r) begin
      m_ph  = P_IDLE;
      m_acc = 0;
      m_win = 0;
    end else begin
      if (acc) begin
        if (e.winv) m_win++;
        m_acc++;
        if (m_acc == W * H) begin
          m_acc = 0;
          last  = 1'b1;
        end
      end
      case (m_ph)
        P_IDLE: if (s) m_ph = P_CLR;
        P_CLR: begin
          m_acc = 0;
          m_win = 0;
          m_ph  = a ? P_IDLE : P_RUN;
        end
        P_RUN:  m_ph = a ? P_IDLE : (last ? P_DONE : P_RUN);
        default: m_ph = P_IDLE;
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
  endtask

  // Monitor: per-cycle control check, plus an accept-event check whenever the DUT enables the window.
  always @(negedge clk) begin
    exp_t          e;
    exp_t          act;
    logic [2*CW:0] ea;
    cyc_no++;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      act.rdy  = mif.pix_ready_o;
      act.clr  = mif.win_clr_o;
      act.wen  = mif.win_en_o;
      act.len  = mif.line_en_o;
      act.winv = mif.win_valid_o;
      act.done = mif.frame_done_o;
      act.busy = mif.busy_o;
      act.col  = mif.col_o;
      act.row  = mif.row_o;
      act.cnt  = mif.win_cnt_o;
      chk("ctrl", 64'(act), 64'(e));
    end
    if (mif.win_en_o) begin
      n_acc_seen++;
      if (n_acc_seen == W * H) acc64_cyc = cyc_no;
      if (mif.win_valid_o) begin
        n_winp++;
        if (n_winp == 1) first_win = n_acc_seen;
      end
      if (acc_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL acc_unexpected: got accept at col %0d row %0d expected none", mif.col_o, mif.row_o);
      end else begin
        ea = acc_q.pop_front();
        chk("acc", 64'({mif.col_o, mif.row_o, mif.win_valid_o}), 64'(ea));
      end
    end
    if (mif.frame_done_o) begin
      n_donep++;
      done_cyc = cyc_no;
    end
    if (mif.win_clr_o) n_clrp++;
  end

  task automatic full_frame(input string nm);
    clear_stats();
    for (int i = 0; i < 68; i++) cyc(1'b1, i == 0, 1'b0, 1'b0);
    idle(2);
    chk({nm, "_windows"}, 64'(n_winp), 64'(NWIN));
    chk({nm, "_win_cnt"}, 64'(mif.win_cnt_o), 64'(NWIN));
    chk({nm, "_accepts"}, 64'(n_acc_seen), 64'(W * H));
    chk({nm, "_done_cnt"}, 64'(n_donep), 64'(1));
    chk({nm, "_done_lat"}, 64'(done_cyc - acc64_cyc), 64'(1));
  endtask

  int s_acc, s_win, s_win_acc, s_win_cyc, s_acc_cyc, s_done, s_done_cyc;

  initial begin
    rst             = 1'b1;
    rst_s           = 1'b1;
    mif.start_i     = 1'b0;
    mif.abort_i     = 1'b0;
    mif.pix_valid_i = 1'b0;
    sif.start_i     = 1'b0;
    sif.abort_i     = 1'b0;
    sif.pix_valid_i = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held: all controls low, counters zero
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Held-valid frame
    full_frame("held");
    chk("first_win_accept", 64'(first_win), 64'(19));
    chk("clr_pulses", 64'(n_clrp), 64'(1));

    // Gapped valid 1,0,0,...
    clear_stats();
    for (int i = 0; i < 196; i++) cyc((i >= 2) && ((i - 2) % 3 == 0), i == 0, 1'b0, 1'b0);
    idle(2);
    chk("gap_windows", 64'(n_winp), 64'(NWIN));
    chk("gap_accepts", 64'(n_acc_seen), 64'(W * H));
    chk("gap_done", 64'(n_donep), 64'(1));

    // Start pulsed mid-RUN is ignored
    clear_stats();
    for (int i = 0; i < 68; i++) cyc(1'b1, (i == 0) || (i == 20) || (i == 45), 1'b0, 1'b0);
    idle(2);
    chk("restart_clr_pulses", 64'(n_clrp), 64'(1));
    chk("restart_windows", 64'(n_winp), 64'(NWIN));
    chk("restart_done", 64'(n_donep), 64'(1));

    // Abort on the 30th accept
    clear_stats();
    for (int i = 0; i < 40; i++) cyc(1'b1, i == 0, i == 31, 1'b0);
    idle(2);
    chk("abort_done", 64'(n_donep), 64'(0));
    chk("abort_win_cnt", 64'(mif.win_cnt_o), 64'(10));
    chk("abort_accepts", 64'(n_acc_seen), 64'(30));
    chk("abort_busy", 64'(mif.busy_o), 64'(0));
    full_frame("after_abort");

    // Reset on the 40th accept
    clear_stats();
    for (int i = 0; i < 45; i++) cyc(1'b1, i == 0, 1'b0, i == 41);
    idle(2);
    chk("rst_win_cnt", 64'(mif.win_cnt_o), 64'(0));
    chk("rst_busy", 64'(mif.busy_o), 64'(0));
    chk("rst_done", 64'(n_donep), 64'(0));

    // Random traffic, starts, aborts and resets
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 199) == 0, $urandom_range(0, 399) == 0);
    end
    idle(3);
    chk("cyc_q_drained", 64'(cyc_q.size()), 64'(0));
    chk("acc_q_drained", 64'(acc_q.size()), 64'(0));

    // Minimal 3x3 image with a 3x3 window
    @(posedge clk);
    #1;
    rst_s = 1'b0;
    s_acc = 0; s_win = 0; s_win_acc = 0; s_win_cyc = -1; s_acc_cyc = -1; s_done = 0; s_done_cyc = -1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk);
      #1;
      sif.start_i     = (i == 0);
      sif.pix_valid_i = 1'b1;
      @(negedge clk);
      if (sif.pix_valid_i && sif.pix_ready_o) begin
        s_acc++;
        s_acc_cyc = i;
      end
      if (sif.win_valid_o) begin
        s_win++;
        s_win_acc = s_acc;
        s_win_cyc = i;
      end
      if (sif.frame_done_o) begin
        s_done++;
        s_done_cyc = i;
      end
    end
    chk("small_accepts", 64'(s_acc), 64'(9));
    chk("small_windows", 64'(s_win), 64'(1));
    chk("small_win_at", 64'(s_win_acc), 64'(9));
    chk("small_win_last", 64'(s_win_cyc), 64'(s_acc_cyc));
    chk("small_done_cnt", 64'(s_done), 64'(1));
    chk("small_done_lat", 64'(s_done_cyc - s_acc_cyc), 64'(1));
    chk("small_win_cnt", 64'(sif.win_cnt_o), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
